// File: rtl/freq_cal_sar.sv
// ---------------------------------------------------------------------------
// freq_cal_sar
//
// Calibration and lock controller for a ring-oscillator-clocked frequency
// divider. The divided output psi is measured in reference-clock cycles.
// The divider preset is then found by successive approximation, MSB first,
// so that the psi period matches a programmed target. Once the search is
// done the block keeps measuring every period. It re-runs the search if
// the lock drifts away.
//
// Ports
//   clk_i          reference clock, rising edge
//   rst_ni         asynchronous active-low reset
//   start_i        1-cycle pulse: latch set_period_i and begin calibration
//   set_period_i   target psi period in clk cycles
//   psi_i          divided ring-oscillator output (asynchronous to clk_i)
//   div_value_o    divider preset value
//   div_load_o     1-cycle pulse: divider (re)loads div_value_o
//   busy_o         calibration search in progress
//   locked_o       last measured period within TOL of the target
//   err_o          calibration finished out of tolerance
//   meas_period_o  last completed period measurement
// ---------------------------------------------------------------------------
module freq_cal_sar #(
   parameter int DIV_W   = 8,
   parameter int CNT_W   = 16,
   parameter int SETTLE  = 2,
   parameter int TOL     = 2,
   parameter int TIMEOUT = 4096
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [CNT_W-1:0] set_period_i,
   input  logic             psi_i,
   output logic [DIV_W-1:0] div_value_o,
   output logic             div_load_o,
   output logic             busy_o,
   output logic             locked_o,
   output logic             err_o,
   output logic [CNT_W-1:0] meas_period_o
);

   localparam int BIT_W = (DIV_W > 1) ? $clog2(DIV_W) : 1;
   localparam int SET_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETTLE,
      ST_MEASURE,
      ST_DECIDE,
      ST_FINAL,
      ST_TRACK
   } state_e;

   state_e             state_q;
   logic [CNT_W-1:0]   tgt_q;
   logic [DIV_W-1:0]   res_q;
   logic [BIT_W-1:0]   bit_q;
   logic               finalPass_q;
   logic [SET_W-1:0]   settleCnt_q;
   logic               missed_q;
   logic [DIV_W-1:0]   divValue_q;
   logic               divLoad_q;
   logic               busy_q;
   logic               locked_q;
   logic               err_q;

   logic               psiMeta_q;
   logic               psiSync_q;
   logic               psiDly_q;
   logic               psiEdge_q;

   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   meas_q;

   logic               timeout_d;
   logic               measEvt_d;
   logic [CNT_W-1:0]   measSample_d;
   logic [DIV_W-1:0]   trialValue_d;
   logic               trackInTol_d;
   logic               finalInTol_d;

   // |meas - tgt| is formed one bit wider than the operands, so a huge
   // measurement (e.g. the saturated timeout value) can never wrap into
   // the tolerance window.
   function automatic logic inTol(input logic [CNT_W-1:0] m,
                                  input logic [CNT_W-1:0] t);
      logic [CNT_W:0] diff;
      if (m >= t) begin
         diff = {1'b0, m} - {1'b0, t};
      end else begin
         diff = {1'b0, t} - {1'b0, m};
      end
      return (diff <= (CNT_W+1)'(TOL));
   endfunction

   // psi is asynchronous. Two flops resynchronise it and a third delays it
   // for rising-edge detection. The edge pulse itself is registered, so a
   // psi edge reaches the rest of the logic three clocks later.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         psiMeta_q <= 1'b0;
         psiSync_q <= 1'b0;
         psiDly_q  <= 1'b0;
         psiEdge_q <= 1'b0;
      end else begin
         psiMeta_q <= psi_i;
         psiSync_q <= psiMeta_q;
         psiDly_q  <= psiSync_q;
         psiEdge_q <= psiSync_q & ~psiDly_q;
      end
   end

   // A measurement completes on a psi edge, or when the counter has run
   // TIMEOUT clocks with no edge. The timeout stays asserted until the
   // next edge, so a stopped psi keeps reporting a saturated period.
   assign timeout_d    = (cnt_q >= CNT_W'(TIMEOUT));
   assign measEvt_d    = psiEdge_q | timeout_d;
   assign measSample_d = psiEdge_q ? cnt_q : '1;

   // The counter restarts at 1 so that it holds exactly the edge-to-edge
   // distance when the next edge arrives. A divider load also restarts it,
   // so the timeout is measured from the moment the new preset is applied.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         meas_q <= '0;
      end else begin
         if ((state_q == ST_LOAD) || psiEdge_q) begin
            cnt_q <= CNT_W'(1);
         end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (measEvt_d && (state_q != ST_IDLE)) begin
            meas_q <= measSample_d;
         end
      end
   end

   assign trialValue_d = res_q | (DIV_W'(1) << bit_q);
   assign trackInTol_d = inTol(measSample_d, tgt_q);
   assign finalInTol_d = inTol(meas_q, tgt_q);

   // Control FSM. All outputs are registered here.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         tgt_q       <= '0;
         res_q       <= '0;
         bit_q       <= '0;
         finalPass_q <= 1'b0;
         settleCnt_q <= '0;
         missed_q    <= 1'b0;
         divValue_q  <= '0;
         divLoad_q   <= 1'b0;
         busy_q      <= 1'b0;
         locked_q    <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         divLoad_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  tgt_q       <= set_period_i;
                  res_q       <= '0;
                  bit_q       <= BIT_W'(DIV_W - 1);
                  finalPass_q <= 1'b0;
                  busy_q      <= 1'b1;
                  locked_q    <= 1'b0;
                  err_q       <= 1'b0;
                  state_q     <= ST_LOAD;
               end
            end

            ST_LOAD: begin
               divValue_q  <= finalPass_q ? res_q : trialValue_d;
               divLoad_q   <= 1'b1;
               settleCnt_q <= '0;
               state_q     <= ST_SETTLE;
            end

            // Early edges after a load may still belong to the previous
            // preset or to a divider that is settling, so they are discarded.
            ST_SETTLE: begin
               if (timeout_d) begin
                  state_q <= ST_MEASURE;
               end else if (psiEdge_q) begin
                  settleCnt_q <= settleCnt_q + 1'b1;
                  if (settleCnt_q == SET_W'(SETTLE - 1)) begin
                     state_q <= ST_MEASURE;
                  end
               end
            end

            // The last settle edge opens the measured period, so the first
            // event seen here closes one full period.
            ST_MEASURE: begin
               if (measEvt_d) begin
                  state_q <= finalPass_q ? ST_FINAL : ST_DECIDE;
               end
            end

            // The period grows with the preset, so a trial bit is kept
            // whenever the measured period does not overshoot the target.
            ST_DECIDE: begin
               if (meas_q <= tgt_q) begin
                  res_q <= trialValue_d;
               end
               if (bit_q == '0) begin
                  finalPass_q <= 1'b1;
               end else begin
                  bit_q <= bit_q - 1'b1;
               end
               state_q <= ST_LOAD;
            end

            ST_FINAL: begin
               busy_q   <= 1'b0;
               locked_q <= finalInTol_d;
               err_q    <= ~finalInTol_d;
               missed_q <= 1'b0;
               state_q  <= ST_TRACK;
            end

            // A single out-of-tolerance period only drops the lock. A second
            // consecutive miss restarts the search with the retained target.
            ST_TRACK: begin
               if (start_i) begin
                  tgt_q       <= set_period_i;
                  res_q       <= '0;
                  bit_q       <= BIT_W'(DIV_W - 1);
                  finalPass_q <= 1'b0;
                  busy_q      <= 1'b1;
                  locked_q    <= 1'b0;
                  err_q       <= 1'b0;
                  state_q     <= ST_LOAD;
               end else if (measEvt_d) begin
                  if (trackInTol_d) begin
                     locked_q <= 1'b1;
                     missed_q <= 1'b0;
                  end else begin
                     locked_q <= 1'b0;
                     if (missed_q) begin
                        missed_q    <= 1'b0;
                        res_q       <= '0;
                        bit_q       <= BIT_W'(DIV_W - 1);
                        finalPass_q <= 1'b0;
                        busy_q      <= 1'b1;
                        err_q       <= 1'b0;
                        state_q     <= ST_LOAD;
                     end else begin
                        missed_q <= 1'b1;
                     end
                  end
               end
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign div_value_o   = divValue_q;
   assign div_load_o    = divLoad_q;
   assign busy_o        = busy_q;
   assign locked_o      = locked_q;
   assign err_o         = err_q;
   assign meas_period_o = meas_q;

endmodule
